// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-back/write-allocate data cache controller
//
// Purpose: owns the tag/valid/dirty arrays of a direct-mapped data cache and
// sequences line write-back and refill over a word-serial memory handshake.
// The data RAM itself is external; this block only drives its controls.
// Optional feature macro: CACHE_STATS_EN (adds Hit_Count / Miss_Count).
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   MemRead, MemWrite   core load/store request (both set = store)
//   Addr                core byte address {tag, index, word, 2'b00}
//   Stall               freeze core pipeline
//   DA_Index, DA_Word   data-array line / word select
//   DA_WE, DA_Sel       data-array write enable, source (0=core, 1=memory)
//   MEM_Req, MEM_Write  memory beat request, direction (1=write-back)
//   MEM_Addr            word-aligned beat address
//   MEM_Ack             beat accepted / read data valid
//   Hit_Count, Miss_Count  saturating statistics (CACHE_STATS_EN only)

module cache_controller #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_W-1:0]     Addr,
  output logic                  Stall,
  output logic [INDEX_W-1:0]    DA_Index,
  output logic [OFFSET_W-3:0]   DA_Word,
  output logic                  DA_WE,
  output logic                  DA_Sel,
  output logic                  MEM_Req,
  output logic                  MEM_Write,
  output logic [ADDR_W-1:0]     MEM_Addr,
  input  logic                  MEM_Ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           Hit_Count,
  output logic [31:0]           Miss_Count
`endif
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_W = OFFSET_W - 2;
  localparam int LINES  = 2 ** INDEX_W;
  localparam logic [WORD_W-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_beat;
  logic [ADDR_W-1:0]   r_miss_addr;
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic [TAG_W-1:0]    r_tag [LINES];

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_idx;
  logic [WORD_W-1:0]   w_word;
  logic [TAG_W-1:0]    w_miss_tag;
  logic [INDEX_W-1:0]  w_miss_idx;
  logic [TAG_W-1:0]    w_old_tag;
  logic                w_req;
  logic                w_hit;
  logic                w_idle_hit;
  logic                w_idle_miss;
  logic                w_last_ack;
  logic                w_unused;

  assign w_tag      = Addr[ADDR_W-1 -: TAG_W];
  assign w_idx      = Addr[OFFSET_W +: INDEX_W];
  assign w_word     = Addr[2 +: WORD_W];
  assign w_miss_tag = r_miss_addr[ADDR_W-1 -: TAG_W];
  assign w_miss_idx = r_miss_addr[OFFSET_W +: INDEX_W];
  assign w_old_tag  = r_tag[w_miss_idx];
  assign w_unused   = ^{Addr[1:0], r_miss_addr[OFFSET_W-1:0]};

  assign w_req       = MemRead | MemWrite;
  assign w_hit       = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_idle_hit  = (r_state == S_IDLE) & w_req & w_hit;
  assign w_idle_miss = (r_state == S_IDLE) & w_req & ~w_hit;
  // Last refill beat accepted: the line becomes valid with the missed tag.
  assign w_last_ack  = (r_state == S_REFILL) & MEM_Ack & (r_beat == LAST_BEAT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_miss_addr <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_idle_hit) begin
            if (MemWrite) r_dirty[w_idx] <= 1'b1;
          end else if (w_idle_miss) begin
            r_miss_addr <= Addr;
            r_beat      <= '0;
            // The victim is dropped now so an abandoned burst never leaves a
            // half-refilled line looking valid; the old tag stays for write-back.
            r_valid[w_idx] <= 1'b0;
            if (r_valid[w_idx] & r_dirty[w_idx]) r_state <= S_WRITEBACK;
            else                                 r_state <= S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (MEM_Ack) begin
            if (r_beat == LAST_BEAT) begin
              r_beat  <= '0;
              r_state <= S_REFILL;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_REFILL: begin
          if (MEM_Ack) begin
            if (r_beat == LAST_BEAT) begin
              r_beat               <= '0;
              r_valid[w_miss_idx]  <= 1'b1;
              r_dirty[w_miss_idx]  <= 1'b0;
              r_state              <= S_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tags are never cleared; valid alone qualifies them.
  always_ff @(posedge CLK) begin
    if (!RST && w_last_ack) r_tag[w_miss_idx] <= w_miss_tag;
  end

  // Outputs are decoded combinationally so a hit costs no added cycle and a
  // miss stalls the core in the very cycle it is detected.
  always_comb begin
    Stall     = 1'b0;
    DA_Index  = w_idx;
    DA_Word   = w_word;
    DA_WE     = 1'b0;
    DA_Sel    = 1'b0;
    MEM_Req   = 1'b0;
    MEM_Write = 1'b0;
    MEM_Addr  = '0;
    case (r_state)
      S_IDLE: begin
        Stall = w_idle_miss;
        DA_WE = w_idle_hit & MemWrite;
      end
      S_WRITEBACK: begin
        Stall     = 1'b1;
        DA_Index  = w_miss_idx;
        DA_Word   = r_beat;
        MEM_Req   = 1'b1;
        MEM_Write = 1'b1;
        MEM_Addr  = {w_old_tag, w_miss_idx, r_beat, 2'b00};
      end
      S_REFILL: begin
        Stall    = 1'b1;
        DA_Index = w_miss_idx;
        DA_Word  = r_beat;
        DA_WE    = MEM_Ack;
        DA_Sel   = 1'b1;
        MEM_Req  = 1'b1;
        MEM_Addr = {w_miss_tag, w_miss_idx, r_beat, 2'b00};
      end
      default: Stall = 1'b1;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_idle_hit && r_hit_count != 32'hFFFF_FFFF)
        r_hit_count <= r_hit_count + 32'd1;
      if (w_idle_miss && r_miss_count != 32'hFFFF_FFFF)
        r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign Hit_Count  = r_hit_count;
  assign Miss_Count = r_miss_count;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench for cache_controller

module tb_cache_controller;

  logic        CLK;
  logic        RST;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic        Stall;
  logic [4:0]  DA_Index;
  logic [1:0]  DA_Word;
  logic        DA_WE;
  logic        DA_Sel;
  logic        MEM_Req;
  logic        MEM_Write;
  logic [31:0] MEM_Addr;
  logic        MEM_Ack;
`ifdef CACHE_STATS_EN
  logic [31:0] Hit_Count;
  logic [31:0] Miss_Count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cache_controller dut (
    .CLK       (CLK),
    .RST       (RST),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .Stall     (Stall),
    .DA_Index  (DA_Index),
    .DA_Word   (DA_Word),
    .DA_WE     (DA_WE),
    .DA_Sel    (DA_Sel),
    .MEM_Req   (MEM_Req),
    .MEM_Write (MEM_Write),
    .MEM_Addr  (MEM_Addr),
    .MEM_Ack   (MEM_Ack)
`ifdef CACHE_STATS_EN
    ,
    .Hit_Count (Hit_Count),
    .Miss_Count(Miss_Count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Four beats at full-rate ack; wr=1 for write-back, 0 for refill.
  task automatic burst(input string tag, input logic [31:0] base, input logic wr);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("%s_stall%0d", tag, i), 32'(Stall), 32'd1);
      chk($sformatf("%s_req%0d", tag, i), 32'(MEM_Req), 32'd1);
      chk($sformatf("%s_mwr%0d", tag, i), 32'(MEM_Write), 32'(wr));
      chk($sformatf("%s_maddr%0d", tag, i), MEM_Addr, base + 32'(4 * i));
      chk($sformatf("%s_daword%0d", tag, i), 32'(DA_Word), 32'(i));
      chk($sformatf("%s_dawe%0d", tag, i), 32'(DA_WE), 32'(!wr));
      chk($sformatf("%s_dasel%0d", tag, i), 32'(DA_Sel), 32'(!wr));
      next_cycle();
    end
  endtask

  initial begin
    RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'h0; MEM_Ack = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_req", 32'(MEM_Req), 32'd0);
    chk("rst_mwr", 32'(MEM_Write), 32'd0);
    chk("rst_dawe", 32'(DA_WE), 32'd0);
    chk("rst_dasel", 32'(DA_Sel), 32'd0);
    chk("rst_maddr", MEM_Addr, 32'h0);
`ifdef CACHE_STATS_EN
    chk("rst_hits", Hit_Count, 32'd0);
    chk("rst_miss", Miss_Count, 32'd0);
`endif
    next_cycle();

    // 1: cold read miss at 0x40, clean refill, retry hits.
    MemRead = 1'b1; Addr = 32'h40;
    #1;
    chk("t1_miss_stall", 32'(Stall), 32'd1);
    chk("t1_miss_req", 32'(MEM_Req), 32'd0);
    next_cycle();
    burst("t1_refill", 32'h40, 1'b0);
    #1;
    chk("t1_retry_stall", 32'(Stall), 32'd0);
    chk("t1_retry_req", 32'(MEM_Req), 32'd0);
    next_cycle();

    // 2: read hit on another word of the line.
    Addr = 32'h44;
    #1;
    chk("t2_stall", 32'(Stall), 32'd0);
    chk("t2_req", 32'(MEM_Req), 32'd0);
    chk("t2_index", 32'(DA_Index), 32'd4);
    chk("t2_word", 32'(DA_Word), 32'd1);
    chk("t2_dawe", 32'(DA_WE), 32'd0);
    next_cycle();

    // 3: write hit dirties the line, then conflicting read forces write-back.
    MemRead = 1'b0; MemWrite = 1'b1; Addr = 32'h48;
    #1;
    chk("t3_wr_dawe", 32'(DA_WE), 32'd1);
    chk("t3_wr_dasel", 32'(DA_Sel), 32'd0);
    chk("t3_wr_stall", 32'(Stall), 32'd0);
    chk("t3_wr_word", 32'(DA_Word), 32'd2);
`ifdef CACHE_STATS_EN
    // 6: one miss and two hits (retry + 0x44) by now.
    chk("t6_hits", Hit_Count, 32'd2);
    chk("t6_miss", Miss_Count, 32'd1);
`endif
    next_cycle();
    MemWrite = 1'b0; MemRead = 1'b1; Addr = 32'h240;
    #1;
    chk("t3_miss_stall", 32'(Stall), 32'd1);
    next_cycle();
    burst("t3_wb", 32'h40, 1'b1);
    burst("t3_refill", 32'h240, 1'b0);
    #1;
    chk("t3_retry_stall", 32'(Stall), 32'd0);
    chk("t3_retry_index", 32'(DA_Index), 32'd4);
    next_cycle();

    // 4: refill of 0x80 with MEM_Ack low for 3 cycles before beat 2.
    Addr = 32'h80;
    #1;
    chk("t4_miss_stall", 32'(Stall), 32'd1);
    next_cycle();
    next_cycle();
    next_cycle();
    MEM_Ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t4_hold_maddr%0d", i), MEM_Addr, 32'h88);
      chk($sformatf("t4_hold_word%0d", i), 32'(DA_Word), 32'd2);
      chk($sformatf("t4_hold_stall%0d", i), 32'(Stall), 32'd1);
      chk($sformatf("t4_hold_req%0d", i), 32'(MEM_Req), 32'd1);
      chk($sformatf("t4_hold_dawe%0d", i), 32'(DA_WE), 32'd0);
      next_cycle();
    end
    MEM_Ack = 1'b1;
    #1;
    chk("t4_beat2_maddr", MEM_Addr, 32'h88);
    chk("t4_beat2_dawe", 32'(DA_WE), 32'd1);
    next_cycle();
    #1;
    chk("t4_beat3_maddr", MEM_Addr, 32'h8C);
    next_cycle();
    #1;
    chk("t4_retry_stall", 32'(Stall), 32'd0);
    next_cycle();

    // 5: reset during refill beat 2 of 0xC0, then 0x80 misses again.
    Addr = 32'hC0;
    #1;
    chk("t5_miss_stall", 32'(Stall), 32'd1);
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    chk("t5_beat2_maddr", MEM_Addr, 32'hC8);
    RST = 1'b1;
    next_cycle();
    RST = 1'b0; MemRead = 1'b0;
    #1;
    chk("t5_post_stall", 32'(Stall), 32'd0);
    chk("t5_post_req", 32'(MEM_Req), 32'd0);
    next_cycle();
    MemRead = 1'b1; Addr = 32'h80;
    #1;
    chk("t5_remiss_stall", 32'(Stall), 32'd1);
    next_cycle();
    burst("t5_refill", 32'h80, 1'b0);
    #1;
    chk("t5_retry_stall", 32'(Stall), 32'd0);
    next_cycle();

    // Both MemRead and MemWrite: treated as a write hit.
    MemWrite = 1'b1; Addr = 32'h84;
    #1;
    chk("rw_dawe", 32'(DA_WE), 32'd1);
    chk("rw_dasel", 32'(DA_Sel), 32'd0);
    chk("rw_stall", 32'(Stall), 32'd0);
    chk("rw_word", 32'(DA_Word), 32'd1);
    next_cycle();
    MemRead = 1'b0; MemWrite = 1'b0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
